dic_cmd_seq: RTL and testbench

- Parametrised successor to the digital-clock UART command controller.
- Accepts ASCII characters from the UART receiver and runs a command sequencer that:
  - sets the running time over NDIG BCD digits (MM:SS by default, HH:MM:SS at NDIG=6);
  - programs any of NALM alarm slots;
  - toggles per-slot alarm enables.
- Sits between the UART rx and the time/alarm counter datapath. Outputs are registered load strobes plus a shared BCD entry buffer.

---
 rtl/dic_pkg.sv | 43 ++++
 rtl/dic_key_class.sv | 30 +++
 rtl/dic_cmd_seq.sv | 185 ++++++++++++++++++
 tb/tb_dic_cmd_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dic_pkg.sv
// Shared definitions for the digital-clock UART command sequencer.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
package dic_pkg;

    // ASCII codes the sequencer reacts to (letters in upper case).
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_S   = 8'h53;
    localparam logic [7:0] ASCII_A   = 8'h41;
    localparam logic [7:0] ASCII_N   = 8'h4E;
    localparam logic [7:0] ASCII_AT  = 8'h40;
    localparam logic [7:0] ASCII_0   = 8'h30;

    // Clearing this bit folds a lower-case letter onto its upper-case code.
    localparam logic [7:0] CASE_BIT  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_T,
        ST_SEL_A,
        ST_SET_A,
        ST_WAIT_CR,
        ST_SEL_E
    } state_t;

    // Character classes; le5 qualifies digit (digit value 0..5).
    typedef struct packed {
        logic cr;
        logic esc;
        logic s;
        logic a;
        logic n;
        logic at;
        logic digit;
        logic le5;
    } key_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_0 + 8'd9);
    endfunction

endpackage

// File: rtl/dic_key_class.sv
// Purpose: combinational classifier of one received ASCII character.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: rx_data (character in), key (class flags), value (digit value, low nibble).
module dic_key_class
    import dic_pkg::*;
(
    input  logic [7:0] rx_data,
    output key_t       key,
    output logic [3:0] value
);

    logic [7:0] upper;

    always_comb begin
        // Only used for letter matches; folding never aliases CR/ESC/'@'/digits
        // onto a letter because those are compared on the raw code.
        upper     = rx_data & ~CASE_BIT;
        value     = rx_data[3:0];
        key       = '0;
        key.cr    = (rx_data == ASCII_CR);
        key.esc   = (rx_data == ASCII_ESC);
        key.at    = (rx_data == ASCII_AT);
        key.s     = (upper == ASCII_S);
        key.a     = (upper == ASCII_A);
        key.n     = (upper == ASCII_N);
        key.digit = is_digit(rx_data);
        key.le5   = is_digit(rx_data) && (rx_data[3:0] <= 4'd5);
    end

endmodule

// File: rtl/dic_cmd_seq.sv
// Purpose: UART command sequencer for the digital clock: time set, alarm
//   program and alarm-enable toggle commands, feeding the counter datapath.
// Latency: err / ld_time / ld_alarm appear 1 cycle after the rx_data_rdy cycle.
// Backpressure: none; one character per cycle is accepted back to back.
// Ports: clk, rst (async active-low); rx_data_rdy/rx_data from the UART rx;
//   run, entry_active, dig_ptr, digits, ld_time, ld_alarm, alm_sel,
//   alarm_ena, led_sel, err towards the counters and display.
module dic_cmd_seq
    import dic_pkg::*;
#(
    parameter  int NDIG = 4,
    parameter  int NALM = 2,
    localparam int SELW = (NALM > 1) ? $clog2(NALM) : 1,
    localparam int PTRW = ($clog2(NDIG + 1) > 1) ? $clog2(NDIG + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_data_rdy,
    input  logic [7:0]        rx_data,
    output logic              run,
    output logic              entry_active,
    output logic [PTRW-1:0]   dig_ptr,
    output logic [4*NDIG-1:0] digits,
    output logic              ld_time,
    output logic              ld_alarm,
    output logic [SELW-1:0]   alm_sel,
    output logic [NALM-1:0]   alarm_ena,
    output logic              led_sel,
    output logic              err
);

    key_t              key;
    logic [3:0]        value;

    state_t            state, state_n;
    logic              is_time, is_time_n;
    logic [4*NDIG-1:0] digits_n;
    logic [PTRW-1:0]   ptr_n;
    logic [SELW-1:0]   sel_n;
    logic [NALM-1:0]   ena_n;
    logic              led_n, run_n, ld_time_n, ld_alarm_n, err_n;
    logic              slot_ok, digit_ok;

    dic_key_class u_key (
        .rx_data (rx_data),
        .key     (key),
        .value   (value)
    );

    assign entry_active = (state == ST_SET_T) || (state == ST_SET_A) ||
                          (state == ST_WAIT_CR);

    // Slot digit must address an existing alarm.
    assign slot_ok  = key.digit && ({28'd0, value} < 32'(NALM));
    // Even positions are tens of minutes/seconds/hours: capped at 5.
    assign digit_ok = key.digit && (dig_ptr[0] || key.le5);

    always_comb begin
        state_n    = state;
        is_time_n  = is_time;
        digits_n   = digits;
        ptr_n      = dig_ptr;
        sel_n      = alm_sel;
        ena_n      = alarm_ena;
        led_n      = led_sel;
        run_n      = run;
        ld_time_n  = 1'b0;
        ld_alarm_n = 1'b0;
        err_n      = 1'b0;

        if (rx_data_rdy) begin
            if ((state != ST_IDLE) && key.esc) begin
                // Silent abort: nothing loaded, clock resumes.
                state_n = ST_IDLE;
                run_n   = 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (key.s) begin
                            state_n   = ST_SET_T;
                            is_time_n = 1'b1;
                            run_n     = 1'b0;
                            digits_n  = '0;
                            ptr_n     = '0;
                        end else if (key.a) begin
                            state_n = ST_SEL_A;
                        end else if (key.at) begin
                            state_n = ST_SEL_E;
                        end else if (key.n) begin
                            led_n = ~led_sel;
                        end else if (!key.cr) begin
                            err_n = 1'b1;
                        end
                    end
                    ST_SEL_A: begin
                        if (slot_ok) begin
                            state_n   = ST_SET_A;
                            is_time_n = 1'b0;
                            sel_n     = value[SELW-1:0];
                            digits_n  = '0;
                            ptr_n     = '0;
                        end else begin
                            state_n = ST_IDLE;
                            err_n   = 1'b1;
                        end
                    end
                    ST_SEL_E: begin
                        state_n = ST_IDLE;
                        if (slot_ok) begin
                            for (int i = 0; i < NALM; i++) begin
                                if (value == 4'(i)) begin
                                    ena_n[i] = ~alarm_ena[i];
                                end
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    ST_SET_T, ST_SET_A: begin
                        if (key.cr) begin
                            state_n = ST_IDLE;
                            run_n   = 1'b1;
                            err_n   = 1'b1;
                        end else if (digit_ok) begin
                            for (int i = 0; i < NDIG; i++) begin
                                if (dig_ptr == PTRW'(i)) begin
                                    digits_n[4*(NDIG-1-i) +: 4] = value;
                                end
                            end
                            ptr_n = dig_ptr + 1'b1;
                            if (ptr_n == PTRW'(NDIG)) begin
                                state_n = ST_WAIT_CR;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    ST_WAIT_CR: begin
                        if (key.cr) begin
                            state_n    = ST_IDLE;
                            run_n      = 1'b1;
                            ld_time_n  = is_time;
                            ld_alarm_n = ~is_time;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                        run_n   = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            is_time   <= 1'b0;
            digits    <= '0;
            dig_ptr   <= '0;
            alm_sel   <= '0;
            alarm_ena <= '0;
            led_sel   <= 1'b0;
            run       <= 1'b1;
            ld_time   <= 1'b0;
            ld_alarm  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            is_time   <= is_time_n;
            digits    <= digits_n;
            dig_ptr   <= ptr_n;
            alm_sel   <= sel_n;
            alarm_ena <= ena_n;
            led_sel   <= led_n;
            run       <= run_n;
            ld_time   <= ld_time_n;
            ld_alarm  <= ld_alarm_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_dic_cmd_seq.sv
// Bench for dic_cmd_seq: instance a (NDIG=4, NALM=2), instance b (NDIG=6, NALM=4).
// Each character is one rx_data_rdy cycle; outputs are compared at the next negedge.
module tb_dic_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rdy_a, rdy_b;

    logic        run_a, ea_a, ldt_a, lda_a, err_a, led_a;
    logic [2:0]  ptr_a;
    logic [15:0] dig_a;
    logic [0:0]  sel_a;
    logic [1:0]  ena_a;

    logic        run_b, ea_b, ldt_b, lda_b, err_b, led_b;
    logic [2:0]  ptr_b;
    logic [23:0] dig_b;
    logic [1:0]  sel_b;
    logic [3:0]  ena_b;

    always #5 clk = ~clk;

    dic_cmd_seq #(.NDIG(4), .NALM(2)) dut_a (
        .clk(clk), .rst(rst), .rx_data_rdy(rdy_a), .rx_data(rx_data),
        .run(run_a), .entry_active(ea_a), .dig_ptr(ptr_a), .digits(dig_a),
        .ld_time(ldt_a), .ld_alarm(lda_a), .alm_sel(sel_a), .alarm_ena(ena_a),
        .led_sel(led_a), .err(err_a)
    );

    dic_cmd_seq #(.NDIG(6), .NALM(4)) dut_b (
        .clk(clk), .rst(rst), .rx_data_rdy(rdy_b), .rx_data(rx_data),
        .run(run_b), .entry_active(ea_b), .dig_ptr(ptr_b), .digits(dig_b),
        .ld_time(ldt_b), .ld_alarm(lda_b), .alm_sel(sel_b), .alarm_ena(ena_b),
        .led_sel(led_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what command is being typed and what has been typed.
    localparam int M_IDLE = 0, M_TDIG = 1, M_SELA = 2, M_ADIG = 3, M_WAIT = 4, M_SELE = 5;
    int m_mode[2], m_ptr[2], m_sel[2], m_ena[2], m_led[2], m_run[2];
    int m_err[2], m_ldt[2], m_lda[2], m_tcmd[2];
    int m_dig[2][8];

    function automatic int nd(input int k);
        return (k == 0) ? 4 : 6;
    endfunction

    function automatic int na(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_ptr[k] = 0; m_sel[k] = 0; m_ena[k] = 0;
            m_led[k] = 0; m_run[k] = 1; m_err[k] = 0; m_ldt[k] = 0;
            m_lda[k] = 0; m_tcmd[k] = 0;
            for (int i = 0; i < 8; i++) m_dig[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [7:0] c);
        int ch, d;
        bit isd;
        m_err[k] = 0; m_ldt[k] = 0; m_lda[k] = 0;
        if (!v) return;
        ch = int'(c);
        if (ch >= 97 && ch <= 122) ch = ch - 32;
        isd = (ch >= 48) && (ch <= 57);
        d = ch - 48;
        if (m_mode[k] != M_IDLE && ch == 27) begin
            m_mode[k] = M_IDLE; m_run[k] = 1;
            return;
        end
        case (m_mode[k])
            M_IDLE: begin
                if (ch == 83) begin
                    m_mode[k] = M_TDIG; m_run[k] = 0; m_tcmd[k] = 1; m_ptr[k] = 0;
                    for (int i = 0; i < 8; i++) m_dig[k][i] = 0;
                end else if (ch == 65) m_mode[k] = M_SELA;
                else if (ch == 64) m_mode[k] = M_SELE;
                else if (ch == 78) m_led[k] = 1 - m_led[k];
                else if (ch != 13) m_err[k] = 1;
            end
            M_SELA: begin
                if (isd && d < na(k)) begin
                    m_sel[k] = d; m_ptr[k] = 0; m_tcmd[k] = 0; m_mode[k] = M_ADIG;
                    for (int i = 0; i < 8; i++) m_dig[k][i] = 0;
                end else begin
                    m_err[k] = 1; m_mode[k] = M_IDLE;
                end
            end
            M_SELE: begin
                if (isd && d < na(k)) m_ena[k] = m_ena[k] ^ (1 << d);
                else m_err[k] = 1;
                m_mode[k] = M_IDLE;
            end
            M_TDIG, M_ADIG: begin
                if (ch == 13) begin
                    m_err[k] = 1; m_mode[k] = M_IDLE; m_run[k] = 1;
                end else if (isd && d <= ((m_ptr[k] % 2 == 0) ? 5 : 9)) begin
                    m_dig[k][m_ptr[k]] = d;
                    m_ptr[k]++;
                    if (m_ptr[k] == nd(k)) m_mode[k] = M_WAIT;
                end else m_err[k] = 1;
            end
            M_WAIT: begin
                if (ch == 13) begin
                    if (m_tcmd[k] != 0) m_ldt[k] = 1; else m_lda[k] = 1;
                    m_mode[k] = M_IDLE; m_run[k] = 1;
                end else m_err[k] = 1;
            end
            default: m_mode[k] = M_IDLE;
        endcase
    endtask

    function automatic logic [55:0] exp_vec(input int k);
        logic [31:0] dv;
        logic ea;
        dv = '0;
        for (int i = 0; i < nd(k); i++) dv = dv | (32'(m_dig[k][i]) << (4 * (nd(k) - 1 - i)));
        ea = (m_mode[k] == M_TDIG) || (m_mode[k] == M_ADIG) || (m_mode[k] == M_WAIT);
        return {m_err[k][0], m_ldt[k][0], m_lda[k][0], m_run[k][0], ea, 4'(m_ptr[k]),
                dv, 4'(m_sel[k]), 10'(m_ena[k]), m_led[k][0]};
    endfunction

    function automatic logic [55:0] obs_vec(input int k);
        if (k == 0)
            return {err_a, ldt_a, lda_a, run_a, ea_a, 1'b0, ptr_a, 16'h0, dig_a,
                    3'b0, sel_a, 8'b0, ena_a, led_a};
        return {err_b, ldt_b, lda_b, run_b, ea_b, 1'b0, ptr_b, 8'h0, dig_b,
                2'b0, sel_b, 6'b0, ena_b, led_b};
    endfunction

    // '~' stands for CR and '^' for ESC in the directed strings.
    function automatic logic [7:0] chr(input byte b);
        if (b == 8'h7E) return 8'h0D;
        if (b == 8'h5E) return 8'h1B;
        return 8'(b);
    endfunction

    task automatic put(input int k, input bit v, input logic [7:0] c);
        rx_data = c;
        rdy_a = v && (k == 0);
        rdy_b = v && (k == 1);
        for (int j = 0; j < 2; j++) model_step(j, v && (j == k), c);
    endtask

    task automatic test_reset();
        #12;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (obs_vec(j) !== exp_vec(j)) begin
                errors++; $display("FAIL reset inst=%0d got=%h want=%h", j, obs_vec(j), exp_vec(j));
            end
        end
        checks++;
        if (run_a !== 1'b1 || ea_a !== 1'b0 || dig_a !== 16'h0) begin
            errors++; $display("FAIL reset_const got run=%b ea=%b dig=%h want 1 0 0000", run_a, ea_a, dig_a);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_time_set();
        string s;
        s = "S1234~";
        for (int i = 0; i < s.len(); i++) begin
            put(0, 1, chr(s[i]));
            @(negedge clk);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL time_set step=%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
            if (i == 0) begin
                checks++;
                if (run_a !== 1'b0) begin errors++; $display("FAIL time_set_run got=%b want=0", run_a); end
            end
            if (i == 5) begin
                checks++;
                if (ldt_a !== 1'b1 || run_a !== 1'b1 || dig_a !== 16'h1234) begin
                    errors++; $display("FAIL time_set_load got ld=%b run=%b dig=%h want 1 1 1234", ldt_a, run_a, dig_a);
                end
            end
        end
        put(0, 0, 8'h0);
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== exp_vec(0) || ldt_a !== 1'b0) begin
            errors++; $display("FAIL time_set_end got=%h want=%h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_alarm6();
        string s;
        s = "A3095959~";
        for (int i = 0; i < s.len(); i++) begin
            put(1, 1, chr(s[i]));
            @(negedge clk);
            checks++;
            if (obs_vec(1) !== exp_vec(1) || run_b !== 1'b1) begin
                errors++; $display("FAIL alarm6 step=%0d got=%h want=%h", i, obs_vec(1), exp_vec(1));
            end
        end
        checks++;
        if (lda_b !== 1'b1 || ldt_b !== 1'b0 || sel_b !== 2'd3 || dig_b !== 24'h095959) begin
            errors++; $display("FAIL alarm6_load got lda=%b ldt=%b sel=%0d dig=%h want 1 0 3 095959",
                               lda_b, ldt_b, sel_b, dig_b);
        end
        put(1, 0, 8'h0);
        @(negedge clk);
        checks++;
        if (obs_vec(1) !== exp_vec(1) || lda_b !== 1'b0) begin
            errors++; $display("FAIL alarm6_end got=%h want=%h", obs_vec(1), exp_vec(1));
        end
    endtask

    task automatic test_bad_digit();
        string s;
        s = "S71665 9~";
        for (int i = 0; i < s.len(); i++) begin
            put(0, 1, chr(s[i]));
            @(negedge clk);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL bad_digit step=%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
            if (i == 1 || i == 4 || i == 6) begin
                checks++;
                if (err_a !== 1'b1) begin errors++; $display("FAIL bad_digit_err step=%0d got=%b want=1", i, err_a); end
            end
        end
        checks++;
        if (ldt_a !== 1'b1 || dig_a !== 16'h1659) begin
            errors++; $display("FAIL bad_digit_load got ld=%b dig=%h want 1 1659", ldt_a, dig_a);
        end
    endtask

    task automatic test_early_cr_esc();
        string s;
        s = "S12~S12^";
        for (int i = 0; i < s.len(); i++) begin
            put(0, 1, chr(s[i]));
            @(negedge clk);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL cr_esc step=%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
            if (i == 3 || i == 7) begin
                checks++;
                if (err_a !== (i == 3) || ldt_a !== 1'b0 || run_a !== 1'b1 || ea_a !== 1'b0) begin
                    errors++; $display("FAIL cr_esc_abort step=%0d got err=%b ld=%b run=%b ea=%b", i, err_a, ldt_a, run_a, ea_a);
                end
            end
        end
    endtask

    task automatic test_enable();
        string s;
        s = "@1@1@9n";
        for (int i = 0; i < s.len(); i++) begin
            put(0, 1, chr(s[i]));
            @(negedge clk);
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL enable step=%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
        end
        checks++;
        if (ena_a !== 2'b00 || led_a !== 1'b1) begin
            errors++; $display("FAIL enable_final got ena=%b led=%b want 00 1", ena_a, led_a);
        end
    endtask

    task automatic test_reset_mid();
        string s;
        s = "S12";
        for (int i = 0; i < s.len(); i++) begin
            put(0, 1, chr(s[i]));
            @(negedge clk);
        end
        put(0, 0, 8'h0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec(0) !== exp_vec(0) || run_a !== 1'b1 || ptr_a !== 3'd0) begin
            errors++; $display("FAIL reset_mid got=%h want=%h", obs_vec(0), exp_vec(0));
        end
        @(negedge clk);
        rst = 1'b1;
        s = "34~";
        for (int i = 0; i < s.len(); i++) begin
            put(0, 1, chr(s[i]));
            @(negedge clk);
            checks++;
            if (obs_vec(0) !== exp_vec(0) || ldt_a !== 1'b0 || err_a !== (i < 2)) begin
                errors++; $display("FAIL reset_mid_after step=%0d got=%h want=%h", i, obs_vec(0), exp_vec(0));
            end
        end
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 15))
            0: return 8'h53;   1: return 8'h73;   2: return 8'h41;   3: return 8'h61;
            4: return 8'h4E;   5: return 8'h6E;   6: return 8'h40;   7: return 8'h0D;
            8: return 8'h1B;   9: return 8'h78;
            default: return 8'h30 + 8'($urandom_range(0, 9));
        endcase
    endfunction

    task automatic test_random();
        logic [7:0] q[$];
        int k, kind;
        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 1);
            kind = $urandom_range(0, 4);
            q.delete();
            if (kind == 0 || kind == 1 || kind == 4) begin
                if (kind == 0) q.push_back($urandom_range(0, 1) ? 8'h53 : 8'h73);
                else begin
                    q.push_back($urandom_range(0, 1) ? 8'h41 : 8'h61);
                    q.push_back(8'h30 + 8'($urandom_range(0, 4)));
                end
                for (int p = 0; p < nd(k); p++)
                    q.push_back(8'h30 + 8'($urandom_range(0, (p % 2 == 0) ? 5 : 9)));
                if (kind == 4) q[$urandom_range(1, q.size() - 1)] = rand_char();
                q.push_back(8'h0D);
            end else if (kind == 2) begin
                q.push_back(8'h40);
                q.push_back(8'h30 + 8'($urandom_range(0, 5)));
            end else begin
                for (int n = 0; n < 6; n++) q.push_back(rand_char());
            end
            for (int i = 0; i < q.size(); i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    put(k, 0, 8'h0);
                    @(negedge clk);
                end
                put(k, 1, q[i]);
                @(negedge clk);
                for (int j = 0; j < 2; j++) begin
                    checks++;
                    if (obs_vec(j) !== exp_vec(j)) begin
                        errors++; $display("FAIL random it=%0d inst=%0d chr=%h got=%h want=%h",
                                           it, j, q[i], obs_vec(j), exp_vec(j));
                    end
                end
            end
        end
        put(0, 0, 8'h0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        rx_data = 8'h0;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        model_reset();
        test_reset();
        test_time_set();
        test_alarm6();
        test_bad_digit();
        test_early_cr_esc();
        test_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
